addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq_pkg.sv | 12 +
 rtl/addsub_seq_cla.sv | 32 +++
 rtl/addsub_seq.sv | 120 ++++++++++++
 tb/tb_addsub_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared constants and types for the serial arithmetic blocks.
package addsub_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_seq_cla.sv
// 4-bit carry-lookahead adder slice; also exposes the carry into the MSB
// so callers can derive signed overflow.
module cla_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o,
    output logic       cmsb_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];
    assign cmsb_o = c[3];

endmodule

// File: rtl/addsub_seq.sv
// Serial WIDTH-bit add/subtract: one nibble per RUN cycle through a single
// 4-bit CLA slice, LSB nibble first.
module addsub_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import addsub_seq_pkg::*;

    localparam int unsigned N  = WIDTH / NIBBLE_W;
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                 carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NIBBLE_W-1:0]  a_nib, b_nib, s_nib;
    logic                 s_cout, s_cmsb;
    logic                 accept, last;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla_4 u_cla (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (s_nib),
        .cout_o (s_cout),
        .cmsb_o (s_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        accept  = start && (state_q != RUN);
        last    = (cnt_q == LAST);

        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) sum_d[k*NIBBLE_W +: NIBBLE_W] = s_nib;
                end
                carry_d = s_cout;
                cnt_d   = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    cout_d  = s_cout;
                    ovf_d   = s_cout ^ s_cmsb;
                    state_d = DONE;
                end
            end
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        // Subtraction is a + ~b + 1: invert b once here, seed the carry with sub.
        if (accept) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = sub;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed-vector and sequence bench for addsub_seq at WIDTH=32.
module tb_addsub_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst, start, sub;
    logic [WIDTH-1:0] a, b, sum;
    logic             busy, done, cout, ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: explicit wide addition; overflow from operand/result signs.
    task automatic ref_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic si, output logic [WIDTH-1:0] s,
                          output logic c, output logic o);
        logic [WIDTH:0] full;
        full = {1'b0, ai} + {1'b0, (si ? ~bi : bi)} + {{WIDTH{1'b0}}, si};
        s = full[WIDTH-1:0];
        c = full[WIDTH];
        if (si) o = (ai[WIDTH-1] != bi[WIDTH-1]) && (s[WIDTH-1] != ai[WIDTH-1]);
        else    o = (ai[WIDTH-1] == bi[WIDTH-1]) && (s[WIDTH-1] != ai[WIDTH-1]);
    endtask

    // Called just after a negedge; returns at the negedge where done is seen.
    // Operands are scrambled while busy to show they are latched.
    task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic si, output int lat, output int bcnt,
                          output logic overlap);
        start = 1'b1; a = ai; b = bi; sub = si;
        lat = 0; bcnt = 0; overlap = 1'b0;
        for (int i = 1; i <= 3 * N; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; a = $urandom; b = $urandom; sub = ~si;
            end
            if (busy && done) overlap = 1'b1;
            if (busy) bcnt++;
            if (done) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic verify(input string tag, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input int lat,
                          input int bcnt, input logic overlap);
        check({tag, " latency"}, WIDTH'(lat), WIDTH'(N));
        check({tag, " busy_cycles"}, WIDTH'(bcnt), WIDTH'(N));
        check({tag, " overlap"}, WIDTH'(overlap), '0);
        check({tag, " sum"}, sum, es);
        check({tag, " cout"}, WIDTH'(cout), WIDTH'(ec));
        check({tag, " ovf"}, WIDTH'(ovf), WIDTH'(eo));
    endtask

    initial begin
        int               lat, bcnt, dn_at;
        logic             ovl, rc, ro, rs;
        logic [WIDTH-1:0] ra, rb, rsum;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", WIDTH'(busy), '0);
        check("reset done", WIDTH'(done), '0);
        check("reset sum", sum, '0);
        check("reset cout", WIDTH'(cout), '0);
        check("reset ovf", WIDTH'(ovf), '0);
        rst = 1'b0;

        // Directed vectors; first start coincides with the first cycle out of reset.
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].sub, lat, bcnt, ovl);
            verify($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cout, vecs[v].ovf,
                   lat, bcnt, ovl);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d held_sum", v), sum, vecs[v].sum);
        end

        // Start pulses while busy are ignored; then restart in the done cycle.
        start = 1'b1; a = 32'h10; b = 32'h20; sub = 1'b0;
        dn_at = 0;
        for (int i = 1; i <= 3 * N; i++) begin
            @(negedge clk);
            start = (i >= 2 && i <= 5);
            a = 32'hAAAA_0000 + WIDTH'(i); b = 32'h5555_0000; sub = i[0];
            if (done) begin
                dn_at = i - 1;
                break;
            end
        end
        check("busy_start latency", WIDTH'(dn_at), WIDTH'(N));
        check("busy_start sum", sum, 32'h0000_0030);
        run_op(32'h3, 32'h4, 1'b0, lat, bcnt, ovl);
        verify("done_restart", 32'h0000_0007, 1'b0, 1'b0, lat, bcnt, ovl);

        // Abort mid-operation with reset; start alongside rst must be ignored.
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat, bcnt, ovl);
        start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0; a = '0; b = '0;
        end
        rst = 1'b1; start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort busy", WIDTH'(busy), '0);
        check("abort done", WIDTH'(done), '0);
        check("abort sum", sum, '0);
        check("abort cout", WIDTH'(cout), '0);
        check("abort ovf", WIDTH'(ovf), '0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, bcnt, ovl);
        verify("after_abort", 32'h2345_6789, 1'b0, 1'b0, lat, bcnt, ovl);

        // Back-to-back random operations, each started in the previous done cycle.
        for (int r = 0; r < 1000; r++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
            if (r % 10 == 0) ra = (r % 20 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            ref_op(ra, rb, rs, rsum, rc, ro);
            run_op(ra, rb, rs, lat, bcnt, ovl);
            verify($sformatf("rand%0d", r), rsum, rc, ro, lat, bcnt, ovl);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
